// File: rtl/ram_write_sequencer.sv
// Write-port engine for the 32x3 dual-port RAM: runs stream bursts (valid/ready)
// or constant-fill bursts of Count words starting at a programmed base address.
module ram_write_sequencer #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 3,
   parameter int DEPTH      = 32
) (
   input  logic                  CLOCK_50,
   input  logic                  Reset_n,
   input  logic                  Start,
   input  logic                  Abort,
   input  logic                  Mode,
   input  logic [ADDR_WIDTH-1:0] BaseAddress,
   input  logic [ADDR_WIDTH:0]   Count,
   input  logic [DATA_WIDTH-1:0] FillValue,
   input  logic                  InValid,
   input  logic [DATA_WIDTH-1:0] InData,
   output logic                  InReady,
   output logic                  WrEn,
   output logic [ADDR_WIDTH-1:0] WrAddress,
   output logic [DATA_WIDTH-1:0] WrData,
   output logic                  Busy,
   output logic                  Done,
   output logic [ADDR_WIDTH:0]   WordsWritten
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FILL   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH+1)'(DEPTH);

   state_t                  stateQ, stateD;
   logic [ADDR_WIDTH-1:0]   baseQ, baseD;
   logic [ADDR_WIDTH:0]     countQ, countD;
   logic [DATA_WIDTH-1:0]   fillQ, fillD;
   logic [ADDR_WIDTH:0]     wordsQ, wordsD;
   logic                    wrEnQ, wrEnD;
   logic [ADDR_WIDTH-1:0]   wrAddrQ, wrAddrD;
   logic [DATA_WIDTH-1:0]   wrDataQ, wrDataD;
   logic [ADDR_WIDTH:0]     wordsInc;
   logic [ADDR_WIDTH-1:0]   nextAddr;

   assign wordsInc = wordsQ + 1'b1;
   assign nextAddr = baseQ + wordsQ[ADDR_WIDTH-1:0];

   always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
      if (!Reset_n) begin
         stateQ  <= IDLE;
         baseQ   <= '0;
         countQ  <= '0;
         fillQ   <= '0;
         wordsQ  <= '0;
         wrEnQ   <= 1'b0;
         wrAddrQ <= '0;
         wrDataQ <= '0;
      end else begin
         stateQ  <= stateD;
         baseQ   <= baseD;
         countQ  <= countD;
         fillQ   <= fillD;
         wordsQ  <= wordsD;
         wrEnQ   <= wrEnD;
         wrAddrQ <= wrAddrD;
         wrDataQ <= wrDataD;
      end
   end

   // Address/data registers hold their last value when no write is issued;
   // only WrEn qualifies them for the RAM.
   always_comb begin
      stateD  = stateQ;
      baseD   = baseQ;
      countD  = countQ;
      fillD   = fillQ;
      wordsD  = wordsQ;
      wrEnD   = 1'b0;
      wrAddrD = wrAddrQ;
      wrDataD = wrDataQ;
      unique case (stateQ)
         IDLE: begin
            if (Start && !Abort) begin
               baseD  = BaseAddress;
               fillD  = FillValue;
               countD = (Count == '0 || Count > DepthW) ? DepthW : Count;
               wordsD = '0;
               stateD = Mode ? FILL : STREAM;
            end
         end
         STREAM: begin
            if (Abort) begin
               stateD = IDLE;
            end else if (InValid) begin
               wrEnD   = 1'b1;
               wrAddrD = nextAddr;
               wrDataD = InData;
               wordsD  = wordsInc;
               if (wordsInc == countQ) stateD = DONE;
            end
         end
         FILL: begin
            if (Abort) begin
               stateD = IDLE;
            end else begin
               wrEnD   = 1'b1;
               wrAddrD = nextAddr;
               wrDataD = fillQ;
               wordsD  = wordsInc;
               if (wordsInc == countQ) stateD = DONE;
            end
         end
         DONE: begin
            stateD = IDLE;
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   assign InReady      = (stateQ == STREAM);
   assign Busy         = (stateQ != IDLE);
   assign Done         = (stateQ == DONE);
   assign WrEn         = wrEnQ;
   assign WrAddress    = wrAddrQ;
   assign WrData       = wrDataQ;
   assign WordsWritten = wordsQ;

endmodule

// File: tb/tb_ram_write_sequencer.sv
// Scoreboard bench for ram_write_sequencer: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares every WrEn cycle.
module tb_ram_write_sequencer;

   logic       clk;
   logic       resetN;
   logic       start;
   logic       abortIn;
   logic       mode;
   logic [4:0] baseAddress;
   logic [5:0] count;
   logic [2:0] fillValue;
   logic       inValid;
   logic [2:0] inData;
   logic       inReady;
   logic       wrEn;
   logic [4:0] wrAddress;
   logic [2:0] wrData;
   logic       busy;
   logic       done;
   logic [5:0] wordsWritten;

   int passCount  = 0;
   int checkCount = 0;
   int doneCount  = 0;
   int expAddr[$];
   int expData[$];

   ram_write_sequencer #(.ADDR_WIDTH(5), .DATA_WIDTH(3), .DEPTH(32)) dut (
      .CLOCK_50    (clk),
      .Reset_n     (resetN),
      .Start       (start),
      .Abort       (abortIn),
      .Mode        (mode),
      .BaseAddress (baseAddress),
      .Count       (count),
      .FillValue   (fillValue),
      .InValid     (inValid),
      .InData      (inData),
      .InReady     (inReady),
      .WrEn        (wrEn),
      .WrAddress   (wrAddress),
      .WrData      (wrData),
      .Busy        (busy),
      .Done        (done),
      .WordsWritten(wordsWritten)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic pushWrite(input int addr, input int data);
      expAddr.push_back(addr);
      expData.push_back(data);
   endtask

   // Scoreboard monitor: every write the DUT issues must match the oldest expectation.
   always @(negedge clk) begin
      if (resetN && wrEn) begin
         if (expAddr.size() == 0) begin
            checkOutput("unexpected_write_addr", int'(wrAddress), -1);
         end else begin
            checkOutput("write_addr", int'(wrAddress), expAddr.pop_front());
            checkOutput("write_data", int'(wrData), expData.pop_front());
         end
      end
      if (resetN && done) begin
         doneCount++;
         checkOutput("done_with_last_write", int'(wrEn), 1);
      end
   end

   task automatic applyStart(input logic m, input int base, input int cnt, input int fill);
      start       = 1'b1;
      mode        = m;
      baseAddress = 5'(base);
      count       = 6'(cnt);
      fillValue   = 3'(fill);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic applyStimulus(input logic v, input int d, input logic ab);
      inValid = v;
      inData  = 3'(d);
      abortIn = ab;
      @(posedge clk); #1;
      inValid = 1'b0;
      abortIn = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("idle_reached", int'(busy), 0);
   endtask

   initial begin
      int doneBefore;
      resetN = 1'b0; start = 1'b0; abortIn = 1'b0; mode = 1'b0;
      baseAddress = '0; count = '0; fillValue = '0; inValid = 1'b0; inData = '0;
      #23;
      checkOutput("reset_wren", int'(wrEn), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_inready", int'(inReady), 0);
      checkOutput("reset_words", int'(wordsWritten), 0);
      @(posedge clk); #1;
      resetN = 1'b1;
      @(posedge clk); #1;

      // Fill with wrap
      $display("[TB] fill with wrap");
      doneBefore = doneCount;
      pushWrite(30, 5); pushWrite(31, 5); pushWrite(0, 5); pushWrite(1, 5);
      applyStart(1'b1, 30, 4, 5);
      checkOutput("fill_busy", int'(busy), 1);
      checkOutput("fill_inready", int'(inReady), 0);
      waitIdle(20);
      checkOutput("fill_words", int'(wordsWritten), 4);
      checkOutput("fill_done_pulses", doneCount - doneBefore, 1);

      // Stream with stalls
      $display("[TB] stream with stalls");
      doneBefore = doneCount;
      pushWrite(2, 7); pushWrite(3, 1); pushWrite(4, 6);
      applyStart(1'b0, 2, 3, 0);
      checkOutput("stream_inready", int'(inReady), 1);
      applyStimulus(1'b1, 7, 1'b0);
      applyStimulus(1'b0, 2, 1'b0);
      applyStimulus(1'b1, 1, 1'b0);
      applyStimulus(1'b1, 6, 1'b0);
      checkOutput("stream_inready_after_last", int'(inReady), 0);
      waitIdle(20);
      checkOutput("stream_words", int'(wordsWritten), 3);
      checkOutput("stream_done_pulses", doneCount - doneBefore, 1);

      // Count=0 means a full DEPTH burst
      $display("[TB] count zero fill");
      doneBefore = doneCount;
      for (int i = 0; i < 32; i++) pushWrite((9 + i) % 32, 3);
      applyStart(1'b1, 9, 0, 3);
      waitIdle(60);
      checkOutput("full_words", int'(wordsWritten), 32);
      checkOutput("full_done_pulses", doneCount - doneBefore, 1);

      // Abort after three handshakes
      $display("[TB] abort");
      doneBefore = doneCount;
      pushWrite(10, 1); pushWrite(11, 2); pushWrite(12, 3);
      applyStart(1'b0, 10, 8, 0);
      applyStimulus(1'b1, 1, 1'b0);
      applyStimulus(1'b1, 2, 1'b0);
      applyStimulus(1'b1, 3, 1'b0);
      applyStimulus(1'b1, 4, 1'b1);
      checkOutput("abort_busy", int'(busy), 0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("abort_words", int'(wordsWritten), 3);
      checkOutput("abort_no_done", doneCount - doneBefore, 0);

      // Start while busy is ignored
      $display("[TB] start while busy");
      doneBefore = doneCount;
      for (int i = 0; i < 6; i++) pushWrite(15 + i, 2);
      applyStart(1'b1, 15, 6, 2);
      @(posedge clk); #1;
      applyStart(1'b0, 20, 1, 7);
      waitIdle(20);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("busy_start_idle", int'(busy), 0);
      checkOutput("busy_start_words", int'(wordsWritten), 6);
      checkOutput("busy_start_done_pulses", doneCount - doneBefore, 1);

      // Async reset mid-fill
      $display("[TB] async reset mid-fill");
      pushWrite(0, 1); pushWrite(1, 1); pushWrite(2, 1);
      applyStart(1'b1, 0, 10, 1);
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      resetN = 1'b0;
      #1;
      checkOutput("areset_wren", int'(wrEn), 0);
      checkOutput("areset_busy", int'(busy), 0);
      checkOutput("areset_words", int'(wordsWritten), 0);
      repeat (2) @(posedge clk);
      #1;
      resetN = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("post_reset_busy", int'(busy), 0);
      checkOutput("scoreboard_drained", expAddr.size(), 0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/ram_write_sequencer.md
Name: ram_write_sequencer

Overview:
- Write-side engine for the 32x3 dual-port RAM. It drives the RAM's write port (wren/wraddress/data) while the existing one-second counter scan owns the read port.
- It replaces manual switch-by-switch writing with two programmed bursts, each starting at a base address:
  - a stream burst, where words arrive over a valid/ready handshake;
  - a fill burst, where one constant value is written to N consecutive words.
- It sits between the synchronized switch/key logic (or a future data source) and the RAM instance in the lab top level.

Parameters:
- ADDR_WIDTH, 5, RAM address width; address arithmetic wraps mod 2^ADDR_WIDTH.
- DATA_WIDTH, 3, RAM word width.
- DEPTH, 32, number of RAM words; maximum burst length.

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle request to begin a burst; sampled in IDLE only.
- Abort  in  1  synchronous cancel of the current burst.
- Mode  in  1  0 = stream burst, 1 = fill burst; latched at Start.
- BaseAddress  in  ADDR_WIDTH  first write address; latched at Start.
- Count  in  ADDR_WIDTH+1  burst length; latched at Start.
- FillValue  in  DATA_WIDTH  word written in fill mode; latched at Start.
- InValid  in  1  stream source has InData available.
- InData  in  DATA_WIDTH  stream word.
- InReady  out  1  sequencer accepts InData this cycle.
- WrEn  out  1  RAM write enable (connects to wren).
- WrAddress  out  ADDR_WIDTH  RAM write address (connects to wraddress).
- WrData  out  DATA_WIDTH  RAM write data (connects to data).
- Busy  out  1  high in any state except IDLE.
- Done  out  1  one-cycle pulse when a burst completes normally.
- WordsWritten  out  ADDR_WIDTH+1  number of writes issued in the current or last burst.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - state = IDLE;
  - WrEn, WrAddress, WrData, InReady, Busy, Done = 0;
  - WordsWritten = 0;
  - all latched fields = 0.
- States are IDLE, STREAM, FILL and DONE.
- IDLE:
  - InReady = 0; WrEn = 0 at the next edge.
  - On an edge with Start=1 and Abort=0:
    - latch BaseAddress, Mode and FillValue;
    - latch Count, with 0 or any value greater than DEPTH taken as DEPTH;
    - clear WordsWritten;
    - go to STREAM (Mode=0) or FILL (Mode=1).
- STREAM:
  - InReady = 1, decoded from state.
  - Each edge with InValid=1 is a handshake. The registered outputs become WrEn=1, WrAddress = base + WordsWritten (mod 2^ADDR_WIDTH), WrData = InData.
  - WordsWritten increments on each handshake.
  - Edges without a handshake set WrEn=0.
  - The handshake for word number Count moves the state to DONE at the same edge.
- FILL:
  - InReady = 0.
  - Every edge registers WrEn=1, WrAddress = base + WordsWritten, WrData = FillValue, and increments WordsWritten.
  - The Count-th write moves the state to DONE at the same edge.
  - Result: exactly Count consecutive WrEn-high cycles, with the first one in the cycle after the FILL entry edge.
- DONE:
  - Done = 1 and Busy = 1 for exactly one cycle.
  - The final WrEn=1 is visible in this same cycle.
  - At the next edge: WrEn=0, return to IDLE.
- Latency: 1 cycle from a handshake or fill step to the matching WrEn cycle. There is no combinational path from InData to WrData.
- Address wrap: base + offset rolls 31 -> 0. A burst of DEPTH words starting anywhere writes every address exactly once.
- Abort:
  - Takes effect at an edge in STREAM or FILL: next state IDLE, WrEn=0, no Done pulse.
  - WordsWritten holds the number of writes already issued. A handshake on the Abort edge is not accepted and is not written.
  - Abort has priority over Start in IDLE and over the last-word transition.
- Start while Busy is ignored; the latched fields do not change.
- Reset asserted mid-burst: all outputs drop asynchronously to their reset values. No partial write is emitted after Reset_n rises.
- Busy = (state != IDLE).

Test Plan:
- Fill with wrap: Start, Mode=1, Base=30, Count=4, FillValue=5 -> WrEn high 4 consecutive cycles at addresses 30, 31, 0, 1, all data 5. Done pulses with the 4th write. WordsWritten=4. Busy falls the next cycle.
- Stream with stalls: Mode=0, Base=2, Count=3; InValid pattern 1,0,1,1 with data 7,x,1,6 -> writes (2,7), gap, (3,1), (4,6). InReady drops after the 3rd handshake. Done pulses once.
- Count=0 -> treated as 32. Fill Base=9 writes 32 words covering 9..31 then 0..8. WordsWritten=32.
- Abort: stream Count=8, Abort asserted after 3 handshakes with InValid held high -> exactly 3 writes. No write for the Abort-cycle data. Done never pulses. State IDLE, WordsWritten=3.
- Start ignored while busy: during fill Count=6, pulse Start with Base=20 -> still 6 writes at the original addresses. No second burst begins.
- Async reset mid-fill: drop Reset_n between edges -> WrEn, Busy and WordsWritten go to 0 immediately. After release, no writes occur until a new Start.
